// File: rtl/bus_arbiter.sv
// Two-master arbiter for the external memory pin buffers, with a wait-state sequencer and byte-lane steering.
// Optional anti-starvation for master 1 is enabled by defining BUS_ARB_ANTISTARVE_EN.
//
// state  | meaning
// IDLE   | strobes low (turnaround), sample requests and pick a winner
// ACCESS | strobes driven, wait counter running down to zero
// ACK    | one-cycle ACK pulse to the owner, strobes low
module bus_arbiter #(
    parameter int unsigned WAIT_CYCLES  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        m0_req_i,
    input  logic        m1_req_i,
    input  logic        m0_we_i,
    input  logic        m1_we_i,
    input  logic        m0_byte_i,
    input  logic        m1_byte_i,
    input  logic [15:0] m0_addr_i,
    input  logic [15:0] m1_addr_i,
    input  logic [15:0] m0_dout_i,
    input  logic [15:0] m1_dout_i,
    output logic        m0_ack_o,
    output logic        m1_ack_o,
    output logic [15:0] rdata_o,
    output logic        rd_buf_o,
    output logic        wr0_buf_o,
    output logic        wr1_buf_o,
    output logic [15:0] addr_buf_o,
    output logic [15:0] dout_buf_o,
    input  logic [15:0] din_buf_i,
    output logic        busy_o,
    output logic        owner_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_e;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] dout_q, dout_d;
    logic [15:0] rdata_q, rdata_d;
    logic        rd_q, rd_d;
    logic        wr0_q, wr0_d;
    logic        wr1_q, wr1_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        busy_q, busy_d;
    logic        owner_q, owner_d;

    logic        override;
    logic        any_req;
    logic        win_m1;
    logic        sel_we;
    logic        sel_byte;
    logic [15:0] sel_addr;
    logic [15:0] sel_dout;

    assign any_req  = m0_req_i | m1_req_i;
    assign win_m1   = ~m0_req_i | override;
    assign sel_we   = win_m1 ? m1_we_i   : m0_we_i;
    assign sel_byte = win_m1 ? m1_byte_i : m0_byte_i;
    assign sel_addr = win_m1 ? m1_addr_i : m0_addr_i;
    assign sel_dout = win_m1 ? m1_dout_i : m0_dout_i;

`ifdef BUS_ARB_ANTISTARVE_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;
    logic       override_q, override_d;

    // Counter only advances on M0 grants that leave M1 waiting; the override
    // forces the next grant to M1, so it never runs past the limit.
    always_comb begin
        starve_d   = starve_q;
        override_d = override_q;
        if (state_q == IDLE) begin
            if (!m1_req_i || win_m1) begin
                starve_d   = 4'd0;
                override_d = 1'b0;
            end else begin
                starve_d = starve_q + 4'd1;
                if (starve_d >= STARVE_LIM) begin
                    override_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            starve_q   <= 4'd0;
            override_q <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            override_q <= override_d;
        end
    end

    assign override = override_q;
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT != 0);
    assign override = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;
        rd_d    = rd_q;
        wr0_d   = wr0_q;
        wr1_d   = wr1_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        busy_d  = busy_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = win_m1;
                    addr_d  = sel_addr;
                    // Odd-lane byte writes move the byte to the upper data pins.
                    dout_d  = (sel_byte && sel_addr[0]) ? {sel_dout[7:0], 8'h00} : sel_dout;
                    rd_d    = ~sel_we;
                    wr0_d   = sel_we & (~sel_byte | ~sel_addr[0]);
                    wr1_d   = sel_we & (~sel_byte | sel_addr[0]);
                    wait_d  = WAIT_LD;
                    busy_d  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (wait_q == 4'd0) begin
                    if (rd_q) begin
                        rdata_d = din_buf_i;
                    end
                    rd_d    = 1'b0;
                    wr0_d   = 1'b0;
                    wr1_d   = 1'b0;
                    ack0_d  = ~owner_q;
                    ack1_d  = owner_q;
                    state_d = ACK;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ACK: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                rd_d    = 1'b0;
                wr0_d   = 1'b0;
                wr1_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
            addr_q  <= 16'h0000;
            dout_q  <= 16'h0000;
            rdata_q <= 16'h0000;
            rd_q    <= 1'b0;
            wr0_q   <= 1'b0;
            wr1_q   <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            wr0_q   <= wr0_d;
            wr1_q   <= wr1_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
        end
    end

    assign m0_ack_o   = ack0_q;
    assign m1_ack_o   = ack1_q;
    assign rdata_o    = rdata_q;
    assign rd_buf_o   = rd_q;
    assign wr0_buf_o  = wr0_q;
    assign wr1_buf_o  = wr1_q;
    assign addr_buf_o = addr_q;
    assign dout_buf_o = dout_q;
    assign busy_o     = busy_q;
    assign owner_o    = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed transactions push expected grants, a monitor checks pins and ACKs.
// A second instance with WAIT_CYCLES=0 covers the zero-wait read.
module tb_bus_arbiter;

    localparam int W = 1;

    typedef struct {
        logic        owner;
        logic        rd;
        logic        wr0;
        logic        wr1;
        logic [15:0] addr;
        logic [15:0] dout;
        logic [15:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m1_req, m0_we, m1_we, m0_byte, m1_byte;
    logic [15:0] m0_addr, m1_addr, m0_dout, m1_dout;
    logic        m0_ack, m1_ack, rd_buf, wr0_buf, wr1_buf, busy, owner;
    logic [15:0] rdata, addr_buf, dout_buf, din_buf;

    logic        z_req, z_ack0, z_ack1, z_rd, z_wr0, z_wr1, z_busy, z_owner;
    logic [15:0] z_addr, z_rdata, z_addr_buf, z_dout_buf, z_din;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    assign din_buf = (addr_buf == 16'h1234) ? 16'hBEEF : (addr_buf ^ 16'h5A5A);
    assign z_din   = z_addr_buf ^ 16'h5A5A;

    bus_arbiter #(.WAIT_CYCLES(W), .STARVE_LIMIT(4)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .m0_req_i(m0_req), .m1_req_i(m1_req), .m0_we_i(m0_we), .m1_we_i(m1_we),
        .m0_byte_i(m0_byte), .m1_byte_i(m1_byte), .m0_addr_i(m0_addr), .m1_addr_i(m1_addr),
        .m0_dout_i(m0_dout), .m1_dout_i(m1_dout), .m0_ack_o(m0_ack), .m1_ack_o(m1_ack),
        .rdata_o(rdata), .rd_buf_o(rd_buf), .wr0_buf_o(wr0_buf), .wr1_buf_o(wr1_buf),
        .addr_buf_o(addr_buf), .dout_buf_o(dout_buf), .din_buf_i(din_buf),
        .busy_o(busy), .owner_o(owner)
    );

    bus_arbiter #(.WAIT_CYCLES(0), .STARVE_LIMIT(4)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n),
        .m0_req_i(z_req), .m1_req_i(1'b0), .m0_we_i(1'b0), .m1_we_i(1'b0),
        .m0_byte_i(1'b0), .m1_byte_i(1'b0), .m0_addr_i(z_addr), .m1_addr_i(16'h0000),
        .m0_dout_i(16'h0000), .m1_dout_i(16'h0000), .m0_ack_o(z_ack0), .m1_ack_o(z_ack1),
        .rdata_o(z_rdata), .rd_buf_o(z_rd), .wr0_buf_o(z_wr0), .wr1_buf_o(z_wr1),
        .addr_buf_o(z_addr_buf), .dout_buf_o(z_dout_buf), .din_buf_i(z_din),
        .busy_o(z_busy), .owner_o(z_owner)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic o, input logic r, input logic w0, input logic w1,
                        input logic [15:0] a, input logic [15:0] d, input logic [15:0] rd);
        exp_t e;
        e.owner = o; e.rd = r; e.wr0 = w0; e.wr1 = w1; e.addr = a; e.dout = d; e.rdata = rd;
        exp_q.push_back(e);
    endtask

    task automatic do_txn(input int m, input logic we, input logic byt,
                          input logic [15:0] a, input logic [15:0] d);
        bit got;
        got = 1'b0;
        @(negedge clk);
        if (m == 0) begin
            m0_we = we; m0_byte = byt; m0_addr = a; m0_dout = d; m0_req = 1'b1;
        end else begin
            m1_we = we; m1_byte = byt; m1_addr = a; m1_dout = d; m1_req = 1'b1;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (m == 0) ? m0_ack : m1_ack;
        end
        if (m == 0) m0_req = 1'b0;
        else        m1_req = 1'b0;
        chk("ack_before_timeout", {31'd0, got}, 32'd1);
    endtask

    // Monitor: checks pins on each strobe rise against the queue head, pops on ACK.
    initial begin
        exp_t        e;
        logic        stb, prev_stb, prev_ack, stable;
        logic [15:0] cap_addr, cap_dout;
        logic [2:0]  cap_stb;
        int          stb_cnt, last_ack_cyc;
        prev_stb = 1'b0; prev_ack = 1'b0; stable = 1'b1;
        cap_addr = '0; cap_dout = '0; cap_stb = '0; stb_cnt = 0; last_ack_cyc = -100;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_stb = 1'b0; prev_ack = 1'b0; stb_cnt = 0;
                continue;
            end
            stb = rd_buf | wr0_buf | wr1_buf;
            chk("rd_wr_exclusive", {31'd0, rd_buf & (wr0_buf | wr1_buf)}, 32'd0);
            chk("ack_exclusive", {31'd0, m0_ack & m1_ack}, 32'd0);
            if (stb && !prev_stb) begin
                chk("turnaround", {31'd0, (cyc - last_ack_cyc) >= 2}, 32'd1);
                if (exp_q.size() == 0) begin
                    chk("grant_expected", 32'd0, 32'd1);
                end else begin
                    e = exp_q[0];
                    chk("strobes", {29'd0, rd_buf, wr0_buf, wr1_buf}, {29'd0, e.rd, e.wr0, e.wr1});
                    chk("addr_buf", {16'd0, addr_buf}, {16'd0, e.addr});
                    chk("dout_buf", {16'd0, dout_buf}, {16'd0, e.dout});
                end
                cap_addr = addr_buf; cap_dout = dout_buf; cap_stb = {rd_buf, wr0_buf, wr1_buf};
                stb_cnt = 1; stable = 1'b1;
            end else if (stb) begin
                stb_cnt++;
                if (addr_buf != cap_addr || dout_buf != cap_dout || {rd_buf, wr0_buf, wr1_buf} != cap_stb)
                    stable = 1'b0;
            end
            if (m0_ack || m1_ack) begin
                if (exp_q.size() == 0) begin
                    chk("ack_expected", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_owner", {30'd0, m1_ack, m0_ack}, e.owner ? 32'd2 : 32'd1);
                    chk("owner_o", {31'd0, owner}, {31'd0, e.owner});
                    chk("strobe_cycles", stb_cnt, W + 1);
                    chk("strobe_stable", {31'd0, stable}, 32'd1);
                    if (e.rd) chk("rdata", {16'd0, rdata}, {16'd0, e.rdata});
                end
                last_ack_cyc = cyc;
                stb_cnt = 0;
            end
            if (prev_ack) begin
                chk("busy_after_ack", {31'd0, busy}, 32'd0);
                chk("ack_one_cycle", {31'd0, m0_ack | m1_ack}, 32'd0);
            end
            prev_stb = stb;
            prev_ack = m0_ack | m1_ack;
        end
    end

    initial begin
        int  n;
        bit  seen, got;
        rst_n = 1'b0;
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0; m0_byte = 0; m1_byte = 0;
        m0_addr = '0; m1_addr = '0; m0_dout = '0; m1_dout = '0;
        z_req = 0; z_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_strobes", {29'd0, rd_buf, wr0_buf, wr1_buf}, 32'd0);
        chk("rst_acks_busy", {29'd0, m0_ack, m1_ack, busy}, 32'd0);
        chk("rst_addr_dout", {addr_buf, dout_buf}, 32'd0);
        chk("rst_rdata_owner", {15'd0, rdata, owner}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // M0 read with WAIT=1
        push(0, 1, 0, 0, 16'h1234, 16'h0000, 16'hBEEF);
        do_txn(0, 0, 0, 16'h1234, 16'h0000);
        // M1 odd-lane byte write, then word write
        push(1, 0, 0, 1, 16'h0201, 16'hA500, 16'h0000);
        do_txn(1, 1, 1, 16'h0201, 16'h00A5);
        push(1, 0, 1, 1, 16'h0200, 16'h1357, 16'h0000);
        do_txn(1, 1, 0, 16'h0200, 16'h1357);
        // M0 even-lane byte write, data unsteered
        push(0, 0, 1, 0, 16'h0010, 16'h33CC, 16'h0000);
        do_txn(0, 1, 1, 16'h0010, 16'h33CC);

        // Simultaneous requests: M0 first, M1 after turnaround
        push(0, 1, 0, 0, 16'h4000, 16'h0000, 16'h1A5A);
        push(1, 1, 0, 0, 16'h8001, 16'h0000, 16'hDA5B);
        fork
            do_txn(0, 0, 0, 16'h4000, 16'h0000);
            do_txn(1, 0, 1, 16'h8001, 16'h0000);
        join

        // Reset during a write's ACCESS phase
        push(0, 0, 1, 1, 16'h0300, 16'hCAFE, 16'h0000);
        @(negedge clk);
        m0_we = 1; m0_byte = 0; m0_addr = 16'h0300; m0_dout = 16'hCAFE; m0_req = 1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = wr0_buf | wr1_buf;
        end
        chk("write_strobe_seen", {31'd0, got}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_strobes", {30'd0, wr0_buf, wr1_buf}, 32'd0);
        chk("rst_mid_busy_ack", {29'd0, busy, m0_ack, m1_ack}, 32'd0);
        m0_req = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | m0_ack | m1_ack | busy;
        end
        chk("idle_after_reset", {31'd0, seen}, 32'd0);

        // Continuous requests from both masters
`ifdef BUS_ARB_ANTISTARVE_EN
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) push(0, 1, 0, 0, 16'h0100, 16'h0000, 16'h5B5A);
            push(1, 1, 0, 0, 16'h0202, 16'h0000, 16'h5858);
        end
`else
        for (int j = 0; j < 10; j++) push(0, 1, 0, 0, 16'h0100, 16'h0000, 16'h5B5A);
        push(1, 1, 0, 0, 16'h0202, 16'h0000, 16'h5858);
`endif
        @(negedge clk);
        m0_we = 0; m0_byte = 0; m0_addr = 16'h0100; m0_dout = 0;
        m1_we = 0; m1_byte = 0; m1_addr = 16'h0202; m1_dout = 0;
        m0_req = 1; m1_req = 1;
        n = 0;
        for (int i = 0; i < 200 && m1_req; i++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) n++;
`ifdef BUS_ARB_ANTISTARVE_EN
            if (n == 10) begin m0_req = 0; m1_req = 0; end
`else
            if (n == 10) m0_req = 0;
            if (n == 11) m1_req = 0;
`endif
        end
        m0_req = 0; m1_req = 0;
        repeat (3) @(negedge clk);
        chk("starve_all_acked", exp_q.size(), 32'd0);

        // Zero-wait instance: RD high one cycle, ACK next cycle
        @(negedge clk);
        z_addr = 16'h0055; z_req = 1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = z_rd;
        end
        chk("w0_rd_seen", {31'd0, got}, 32'd1);
        chk("w0_addr", {16'd0, z_addr_buf}, 32'h0055);
        n = 0;
        for (int i = 0; i < 10 && z_rd; i++) begin
            n++;
            @(negedge clk);
        end
        chk("w0_rd_cycles", n, 32'd1);
        chk("w0_ack", {30'd0, z_ack1, z_ack0}, 32'd1);
        chk("w0_rdata", {16'd0, z_rdata}, 32'h5A0F);
        z_req = 0;
        @(negedge clk);
        chk("w0_idle", {30'd0, z_busy, z_ack0}, 32'd0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
